// File: rtl/round_timer_ctrl_pkg.sv
// Shared definitions for the whack-a-mole round sequencer: state encoding,
// field widths and the time-left helper.
package round_timer_ctrl_pkg;

  localparam int SEC_W   = 6;
  localparam int SCORE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    OVER  = 3'd4
  } state_e;

  function automatic logic [SEC_W-1:0] secs_left(input logic [SEC_W-1:0] total,
                                                 input logic [SEC_W-1:0] elapsed);
    return (elapsed >= total) ? '0 : total - elapsed;
  endfunction

endpackage

// File: rtl/round_timer_ctrl_tick_gen.sv
// Seconds prescaler: one-cycle registered tick every CLK_HZ clocks,
// phase re-aligned whenever restart is pulsed.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == TERM) && !restart;
      if (restart || cnt_q == TERM) cnt_q <= '0;
      else                          cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/round_timer_ctrl.sv
// Round sequencer: IDLE -> READY countdown -> PLAY -> PAUSE/OVER, driving the
// external seconds counter and deriving time-left, spawn pulses and score.
module round_timer_ctrl
  import round_timer_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int READY_SECS = 3,
  parameter int ROUND_SECS = 30,
  parameter int SPAWN_SECS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               hit,
  input  logic [SEC_W-1:0]   sec_in,
  output logic               cnt_enable,
  output logic               cnt_clear,
  output logic               tick_1hz,
  output logic [2:0]         state,
  output logic [1:0]         ready_left,
  output logic [SEC_W-1:0]   time_left,
  output logic [SCORE_W-1:0] score,
  output logic               spawn_tick,
  output logic               game_over
);

  localparam logic [1:0]       READY_L = 2'(READY_SECS);
  localparam logic [SEC_W-1:0] ROUND_L = SEC_W'(ROUND_SECS);
  localparam logic [3:0]       SPAWN_L = 4'(SPAWN_SECS);

  logic tick;

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(start_btn),
    .tick   (tick)
  );

  // sec_in crosses domains: two sync flops, then accept only a value seen
  // on two consecutive cycles so a multi-bit change mid-flight is never used.
  logic [SEC_W-1:0] sec_s1_q, sec_s2_q, sec_s3_q, sec_ok_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_s1_q <= '0;
      sec_s2_q <= '0;
      sec_s3_q <= '0;
      sec_ok_q <= '0;
    end else begin
      sec_s1_q <= sec_in;
      sec_s2_q <= sec_s1_q;
      sec_s3_q <= sec_s2_q;
      if (sec_s2_q == sec_s3_q) sec_ok_q <= sec_s2_q;
    end
  end

  state_e             state_q, state_d;
  logic [1:0]         ready_q, ready_d;
  logic [SEC_W-1:0]   time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         spawn_cnt_q, spawn_cnt_d;
  logic               spawn_tick_q, spawn_tick_d;
  logic               enable_q, clear_q, over_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    time_d       = time_q;
    score_d      = score_q;
    spawn_cnt_d  = spawn_cnt_q;
    spawn_tick_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_btn) begin
          state_d = READY;
          ready_d = READY_L;
          score_d = '0;
        end
      end
      READY: begin
        if (start_btn) begin
          ready_d = READY_L;
        end else if (tick && ready_q > 2'd1) begin
          ready_d = ready_q - 2'd1;
        end else if ((tick && ready_q == 2'd1) || ready_q == 2'd0) begin
          ready_d = '0;
          // A stale nonzero second count means the counter has not cleared yet.
          if (sec_ok_q == '0) begin
            state_d     = PLAY;
            spawn_cnt_d = SPAWN_L;
          end
        end
      end
      PLAY: begin
        time_d = secs_left(ROUND_L, sec_ok_q);
        if (hit && score_q != '1) score_d = score_q + 1'b1;
        if (start_btn) begin
          state_d = IDLE;
        end else if (pause_btn) begin
          state_d = PAUSE;
        end else if (sec_ok_q >= ROUND_L) begin
          state_d = OVER;
        end else if (tick) begin
          if (spawn_cnt_q <= 4'd1) begin
            spawn_tick_d = 1'b1;
            spawn_cnt_d  = SPAWN_L;
          end else begin
            spawn_cnt_d = spawn_cnt_q - 4'd1;
          end
        end
      end
      PAUSE: begin
        if (start_btn)      state_d = IDLE;
        else if (pause_btn) state_d = PLAY;
      end
      OVER: begin
        if (start_btn) begin
          state_d = READY;
          ready_d = READY_L;
          score_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = '0;
      end
    endcase

    if (state_d == IDLE || state_d == READY) time_d = ROUND_L;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= '0;
      time_q       <= ROUND_L;
      score_q      <= '0;
      spawn_cnt_q  <= SPAWN_L;
      spawn_tick_q <= 1'b0;
      enable_q     <= 1'b0;
      clear_q      <= 1'b1;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      time_q       <= time_d;
      score_q      <= score_d;
      spawn_cnt_q  <= spawn_cnt_d;
      spawn_tick_q <= spawn_tick_d;
      enable_q     <= (state_d == PLAY);
      clear_q      <= (state_d == IDLE) || (state_d == READY);
      over_q       <= (state_d == OVER);
    end
  end

  assign cnt_enable = enable_q;
  assign cnt_clear  = clear_q;
  assign tick_1hz   = tick;
  assign state      = state_q;
  assign ready_left = ready_q;
  assign time_left  = time_q;
  assign score      = score_q;
  assign spawn_tick = spawn_tick_q;
  assign game_over  = over_q;

endmodule
